sram_port_arbiter: RTL

//  Memory-side responder for the core's inst_sram_* and data_sram_* ports, built on one single-port RAM.

---
 rtl/sram_port_arbiter_pkg.sv | 25 ++
 rtl/sram_port_arbiter_sp_ram_be.sv | 32 +++
 rtl/sram_port_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// Shared types for the SRAM port arbiter: FSM state encoding and the byte-lane
// merge used by the byte-enabled RAM.
package sram_port_arbiter_pkg;

  localparam int WordW   = 32;
  localparam int LaneCnt = WordW / 8;

  typedef enum logic {
    ArbIdle     = 1'b0,
    ArbInstPend = 1'b1
  } arbState_e;

  // Replace only the byte lanes whose enable bit is set.
  function automatic logic [WordW-1:0] mergeLanes(input logic [WordW-1:0]   oldWord,
                                                  input logic [WordW-1:0]   newWord,
                                                  input logic [LaneCnt-1:0] laneEn);
    logic [WordW-1:0] merged;
    merged = oldWord;
    for (int i = 0; i < LaneCnt; i++) begin
      if (laneEn[i]) merged[8*i +: 8] = newWord[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/sram_port_arbiter_sp_ram_be.sv
// Single-port word RAM with per-byte write enables and a one-cycle registered
// read; a write cycle leaves the read output untouched.
module sp_ram_be
  import sram_port_arbiter_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  en_i,
  input  logic [LaneCnt-1:0]    wen_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [WordW-1:0]      wdata_i,
  output logic [WordW-1:0]      rdata_o
);

  logic [WordW-1:0] mem [2**DEPTH_LOG2];
  logic [WordW-1:0] rdata_q;

  // Contents are deliberately never reset; only the arbiter state is.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (wen_i == '0) begin
        rdata_q <= mem[addr_i];
      end else begin
        mem[addr_i] <= mergeLanes(mem[addr_i], wdata_i, wen_i);
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_port_arbiter.sv
// Responder for the core's instruction and data SRAM ports sharing one
// single-port RAM; on a same-cycle collision data wins and the fetch is replayed.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12,
  parameter int CNT_W      = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inst_sram_en,
  input  logic [3:0]         inst_sram_wen,
  input  logic [31:0]        inst_sram_addr,
  input  logic [31:0]        inst_sram_wdata,
  output logic [31:0]        inst_sram_rdata,
  input  logic               data_sram_en,
  input  logic [3:0]         data_sram_wen,
  input  logic [31:0]        data_sram_addr,
  input  logic [31:0]        data_sram_wdata,
  output logic [31:0]        data_sram_rdata,
  output logic               stallreq_for_mem,
  output logic [CNT_W-1:0]   conflict_cnt
);

  arbState_e             state_q, state_d;
  logic [DEPTH_LOG2-1:0] pendAddr_q, pendAddr_d;
  logic [CNT_W-1:0]      conflictCnt_q, conflictCnt_d;
  logic                  servedInst_q, servedInst_d;
  logic                  servedData_q, servedData_d;
  logic [WordW-1:0]      instHold_q, dataHold_q;

  logic                  ramEn;
  logic [LaneCnt-1:0]    ramWen;
  logic [DEPTH_LOG2-1:0] ramAddr;
  logic [WordW-1:0]      ramRdata;
  logic                  stallReq;

  logic [DEPTH_LOG2-1:0] instIdx, dataIdx;
  logic                  unusedBits;

  assign instIdx = inst_sram_addr[DEPTH_LOG2+1:2];
  assign dataIdx = data_sram_addr[DEPTH_LOG2+1:2];

  // Byte offset, high address bits and the write side of the fetch port are don't-cares.
  assign unusedBits = ^{inst_sram_wen, inst_sram_wdata,
                        inst_sram_addr[31:DEPTH_LOG2+2], inst_sram_addr[1:0],
                        data_sram_addr[31:DEPTH_LOG2+2], data_sram_addr[1:0]};

  always_comb begin
    ramEn         = 1'b0;
    ramWen        = '0;
    ramAddr       = dataIdx;
    servedInst_d  = 1'b0;
    servedData_d  = 1'b0;
    state_d       = state_q;
    pendAddr_d    = pendAddr_q;
    conflictCnt_d = conflictCnt_q;
    stallReq      = 1'b0;

    if (rst) begin
      case (state_q)
        ArbIdle: begin
          if (data_sram_en) begin
            ramEn        = 1'b1;
            ramWen       = data_sram_wen;
            ramAddr      = dataIdx;
            servedData_d = (data_sram_wen == '0);
            if (inst_sram_en) begin
              stallReq   = 1'b1;
              pendAddr_d = instIdx;
              state_d    = ArbInstPend;
              if (conflictCnt_q != '1) conflictCnt_d = conflictCnt_q + CNT_W'(1);
            end
          end else if (inst_sram_en) begin
            ramEn        = 1'b1;
            ramAddr      = instIdx;
            servedInst_d = 1'b1;
          end
        end
        // The data request seen here is the stalled repeat of the one already served.
        ArbInstPend: begin
          ramEn        = 1'b1;
          ramAddr      = pendAddr_q;
          servedInst_d = 1'b1;
          state_d      = ArbIdle;
        end
        default: state_d = ArbIdle;
      endcase
    end
  end

  // The RAM output register is shared, so each port keeps its last word in a hold register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ArbIdle;
      pendAddr_q    <= '0;
      conflictCnt_q <= '0;
      servedInst_q  <= 1'b0;
      servedData_q  <= 1'b0;
      instHold_q    <= '0;
      dataHold_q    <= '0;
    end else begin
      state_q       <= state_d;
      pendAddr_q    <= pendAddr_d;
      conflictCnt_q <= conflictCnt_d;
      servedInst_q  <= servedInst_d;
      servedData_q  <= servedData_d;
      if (servedInst_q) instHold_q <= ramRdata;
      if (servedData_q) dataHold_q <= ramRdata;
    end
  end

  sp_ram_be #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) uRam (
    .clk     (clk),
    .en_i    (ramEn),
    .wen_i   (ramWen),
    .addr_i  (ramAddr),
    .wdata_i (data_sram_wdata),
    .rdata_o (ramRdata)
  );

  assign inst_sram_rdata  = servedInst_q ? ramRdata : instHold_q;
  assign data_sram_rdata  = servedData_q ? ramRdata : dataHold_q;
  assign stallreq_for_mem = stallReq;
  assign conflict_cnt     = conflictCnt_q;

endmodule
